// File: rtl/volume_pkg.sv
// Shared constants, enums and arithmetic helpers for the volume/gain datapath.
// sat_round is width-generic so other gain stages (e.g. a mixer) can reuse it.
package volume_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int NUM_CH_DEF    = 2;
    localparam int GAIN_W_DEF    = 8;
    localparam int UNITY_DEF     = 2 ** (GAIN_W_DEF - 1);
    localparam int RAMP_STEP_DEF = 16;

    // Wide enough for any DATA_W + GAIN_W + 1 product this codebase instantiates.
    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    function automatic int unsigned clamp_gain(input int unsigned g, input int unsigned unity);
        return (g > unity) ? unity : g;
    endfunction

    // Round half up after dropping gain_w-1 fraction bits, then clip to data_w signed.
    function automatic wide_t sat_round(input wide_t p, input int gain_w, input int data_w);
        wide_t one;
        wide_t r;
        wide_t hi;
        wide_t lo;
        one = 1;
        r   = (p + (one <<< (gain_w - 2))) >>> (gain_w - 1);
        hi  = (one <<< (data_w - 1)) - one;
        lo  = -(one <<< (data_w - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/gain_mult_sat.sv
// One channel of the gain stage: signed multiply by an unsigned gain,
// round half up, saturate, and register the result.
module gain_mult_sat
    import volume_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic        [GAIN_W-1:0] i_gain,
    output logic signed [DATA_W-1:0] o_y
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    logic signed [GAIN_W:0]   w_gain_s;
    logic signed [PROD_W-1:0] w_prod_p1;

    assign w_gain_s  = $signed({1'b0, i_gain});
    assign w_prod_p1 = PROD_W'(i_x) * PROD_W'(w_gain_s);

    // S1 -> S2 boundary: rounded, saturated sample registered as the output
    always_ff @(posedge clk) begin
        if (reset) begin
            o_y <= '0;
        end else if (i_en) begin
            o_y <= DATA_W'(sat_round({{(WIDE_W-PROD_W){w_prod_p1[PROD_W-1]}}, w_prod_p1},
                                     GAIN_W, DATA_W));
        end
    end

endmodule

// File: rtl/volume_ramp.sv
// Multichannel volume stage with click-free gain ramping on a valid/ready stream.
// Two pipe stages: S1 captures frame + gain, S2 holds the scaled output.
module volume_ramp
    import volume_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [GAIN_W-1:0]        target_gain,
    input  logic                     mute,
    output logic [GAIN_W-1:0]        cur_gain,
    output logic                     ramping
);

    localparam int unsigned        UNITY   = 2 ** (GAIN_W - 1);
    localparam logic [GAIN_W:0]    LP_STEP = (GAIN_W + 1)'(RAMP_STEP);

    logic                     w_en;
    logic                     w_accept;
    logic [GAIN_W-1:0]        w_eff_target;
    logic [GAIN_W-1:0]        w_step_gain;
    logic [GAIN_W-1:0]        w_gain_next;
    logic [GAIN_W:0]          w_diff;
    ramp_state_t              w_state;

    logic                     r_vld_p1;
    logic                     r_vld_p2;
    logic [NUM_CH*DATA_W-1:0] r_data_p1;
    logic [GAIN_W-1:0]        r_gain_p1;
    logic [GAIN_W-1:0]        r_cur_gain;
    logic                     r_ramping;

    assign w_en     = !r_vld_p2 || out_ready;
    assign in_ready = w_en && !reset;
    assign w_accept = in_valid && in_ready;

    assign w_eff_target = mute ? '0 : GAIN_W'(clamp_gain(32'(target_gain), UNITY));

    // Ramp direction is re-derived every cycle, so retargeting takes effect at once.
    always_comb begin
        w_state     = HOLD;
        w_diff      = '0;
        w_step_gain = r_cur_gain;
        if (w_eff_target > r_cur_gain) begin
            w_state = UP;
        end else if (w_eff_target < r_cur_gain) begin
            w_state = DOWN;
        end
        case (w_state)
            UP: begin
                w_diff = {1'b0, w_eff_target} - {1'b0, r_cur_gain};
                if (w_diff <= LP_STEP) begin
                    w_step_gain = w_eff_target;
                end else begin
                    w_step_gain = r_cur_gain + LP_STEP[GAIN_W-1:0];
                end
            end
            DOWN: begin
                w_diff = {1'b0, r_cur_gain} - {1'b0, w_eff_target};
                if (w_diff <= LP_STEP) begin
                    w_step_gain = w_eff_target;
                end else begin
                    w_step_gain = r_cur_gain - LP_STEP[GAIN_W-1:0];
                end
            end
            default: begin
                w_step_gain = r_cur_gain;
            end
        endcase
        w_gain_next = w_accept ? w_step_gain : r_cur_gain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_cur_gain <= '0;
            r_ramping  <= 1'b0;
        end else begin
            if (w_en) begin
                r_vld_p1 <= w_accept;
                r_vld_p2 <= r_vld_p1;
            end
            r_cur_gain <= w_gain_next;
            r_ramping  <= (w_gain_next != w_eff_target);
        end
    end

    // S0 -> S1 boundary: frame captured with the pre-step gain it is scaled by
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data_p1 <= in_data;
            r_gain_p1 <= r_cur_gain;
        end
    end

    // S1 -> S2 boundary: per-channel multiply/round/saturate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        gain_mult_sat #(
            .DATA_W (DATA_W),
            .GAIN_W (GAIN_W)
        ) u_gain_mult_sat (
            .clk    (clk),
            .reset  (reset),
            .i_en   (w_en && r_vld_p1),
            .i_x    (r_data_p1[ch*DATA_W +: DATA_W]),
            .i_gain (r_gain_p1),
            .o_y    (out_data[ch*DATA_W +: DATA_W])
        );
    end

    assign out_valid = r_vld_p2;
    assign cur_gain  = r_cur_gain;
    assign ramping   = r_ramping;

endmodule

// File: tb/tb_volume_ramp.sv
// Directed bench for volume_ramp with a scoreboard of expected output frames.
module tb_volume_ramp;

    localparam int UNITY = 128;
    localparam int STEP  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  target_gain;
    logic        mute;
    logic [7:0]  cur_gain;
    logic        ramping;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [63:0] log_q[$];
    int          m_gain;
    int          m_eff_prev;
    int          base;
    logic [63:0] held_d;
    logic [7:0]  held_g;
    logic [63:0] exp_frame;

    always #5 clk = ~clk;

    volume_ramp #(
        .DATA_W    (32),
        .NUM_CH    (2),
        .GAIN_W    (8),
        .RAMP_STEP (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .target_gain (target_gain),
        .mute        (mute),
        .cur_gain    (cur_gain),
        .ramping     (ramping)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_of(input logic m, input logic [7:0] tg);
        if (m) return 0;
        return (int'(tg) > UNITY) ? UNITY : int'(tg);
    endfunction

    function automatic logic [31:0] scale(input logic [31:0] x, input int g);
        longint p;
        p = longint'($signed(x)) * longint'(g);
        p = (p + 64) >>> 7;
        if (p > 64'sd2147483647) p = 64'sd2147483647;
        if (p < -64'sd2147483648) p = -64'sd2147483648;
        return p[31:0];
    endfunction

    function automatic int step_gain(input int g, input int e);
        if (e - g > STEP) return g + STEP;
        if (g - e > STEP) return g - STEP;
        return e;
    endfunction

    // Observe the handshakes that the coming rising edge will perform, then advance.
    task automatic cycle();
        @(negedge clk);
        if (reset) begin
            sb_q.delete();
            m_gain     = 0;
            m_eff_prev = 0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            check("ramping", 64'(ramping), 64'(m_gain != m_eff_prev));
            if (out_valid && out_ready) begin
                log_q.push_back(out_data);
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    exp_frame = sb_q.pop_front();
                    check("out_data", out_data, exp_frame);
                end
            end
            if (in_valid && in_ready) begin
                check("cur_gain_at_accept", 64'(cur_gain), 64'(m_gain));
                sb_q.push_back({scale(in_data[63:32], m_gain), scale(in_data[31:0], m_gain)});
                m_gain = step_gain(m_gain, eff_of(mute, target_gain));
            end
            m_eff_prev = eff_of(mute, target_gain);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        target_gain = 8'd128; mute = 1'b0; m_gain = 0; m_eff_prev = 0;
        repeat (3) cycle();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_cur_gain", 64'(cur_gain), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_ramping", 64'(ramping), 64'(0));

        // Ramp-up from 0 to unity
        reset = 1'b0; in_valid = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            in_data = {$urandom, $urandom};
            check("ramp_up", 64'(cur_gain), 64'(i * 16));
            cycle();
        end
        check("ramp_done_gain", 64'(cur_gain), 64'(128));
        check("ramp_done_flag", 64'(ramping), 64'(0));
        in_valid = 1'b0;
        repeat (3) cycle();
        check("first_out_zero", log_q[0], 64'(0));

        // Unity passthrough of extreme values
        in_valid = 1'b1; in_data = {32'h80000000, 32'h7FFFFFFF};
        cycle();
        in_valid = 1'b0; in_data = '0;
        cycle();
        check("unity_valid", 64'(out_valid), 64'(1));
        check("unity_data", out_data, 64'h80000000_7FFFFFFF);
        repeat (2) cycle();

        // Rounding at half gain
        target_gain = 8'd64; in_valid = 1'b1; in_data = '0;
        repeat (4) cycle();
        check("half_gain", 64'(cur_gain), 64'(64));
        in_valid = 1'b0;
        repeat (3) cycle();
        base = log_q.size();
        in_valid = 1'b1; in_data = {32'hFFFFFC18, 32'd1000};
        cycle();
        in_data = {32'hFFFFFFFD, 32'd3};
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("rnd_count", 64'(log_q.size()), 64'(base + 2));
        if (log_q.size() >= base + 2) begin
            check("rnd_pos1000", 64'(log_q[base][31:0]), 64'(500));
            check("rnd_neg1000", 64'(log_q[base][63:32]), 64'(32'hFFFFFE0C));
            check("rnd_pos3", 64'(log_q[base+1][31:0]), 64'(2));
            check("rnd_neg3", 64'(log_q[base+1][63:32]), 64'(32'hFFFFFFFF));
        end

        // Backpressure with a full pipe
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = {32'(k), 32'(k * 1000 + 7)};
            cycle();
        end
        out_ready = 1'b0; in_data = {32'd99, 32'd12345};
        held_d = out_data; held_g = cur_gain;
        check("stall_full", 64'(out_valid), 64'(1));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_data", out_data, held_d);
            check("stall_cur_gain", 64'(cur_gain), 64'(held_g));
        end
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (4) cycle();
        check("stall_drained", 64'(sb_q.size()), 64'(0));

        // Mute mid-ramp, then unmute with an over-range target
        target_gain = 8'd128; in_valid = 1'b1;
        repeat (2) cycle();
        check("pre_mute", 64'(cur_gain), 64'(96));
        mute = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = {$urandom, $urandom};
            cycle();
            check("mute_ramp", 64'(cur_gain), 64'(96 - 16 * i));
        end
        cycle();
        check("mute_hold", 64'(cur_gain), 64'(0));
        check("mute_flag", 64'(ramping), 64'(0));
        mute = 1'b0; target_gain = 8'd200;
        repeat (8) cycle();
        check("unmute_clamp", 64'(cur_gain), 64'(128));
        check("unmute_flag", 64'(ramping), 64'(0));

        // Reset mid-stream
        check("pre_rst_full", 64'(out_valid), 64'(1));
        reset = 1'b1;
        cycle();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_data", out_data, 64'(0));
        check("mid_rst_gain", 64'(cur_gain), 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(0));
        reset = 1'b0; target_gain = 8'd128;
        repeat (6) cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("resume_gain", 64'(cur_gain), 64'(96));
        check("resume_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
